irq_pending_collector: RTL and testbench
========================================

Name: irq_pending_collector

Overview:
Upstream stage of the 8-to-3 priority encoder.
- Synchronises 8 raw request lines and detects edges or levels per bit.
- Accumulates requests in a pending register.
- Presents a stable, masked pending snapshot to the encoder over a valid/ready handshake.
- Holds that snapshot until the consumer reports which index it serviced, then clears that pending bit.

Parameters:
- NUM_REQ, 8: request count; fixed at 8 to match the encoder's 8-bit input.
- SYNC_STAGES, 2: flops in each request synchroniser; legal range 2..3.
- EDGE_MASK, 8'hFF: per bit, 1 = rising-edge triggered, 0 = level triggered.
- TIMEOUT_CYCLES, 255: SERVICE watchdog limit; used only with IRQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  8  asynchronous raw request lines.
- mask_i  in  8  1 = bit hidden from the snapshot; capture into pending is unaffected.
- pend_o  out  8  snapshot vector, drives the encoder's `in`.
- pend_valid_o  out  1  snapshot valid.
- pend_ready_i  in  1  consumer accepts snapshot.
- done_i  in  1  one-cycle pulse: service complete.
- done_idx_i  in  3  index serviced; the encoder output, registered by the consumer.
- busy_o  out  1  FSM not IDLE.
- err_o  out  1  one-cycle pulse: done_idx_i not set in the snapshot.
- timeout_o  out  1  one-cycle pulse; present only with IRQ_TIMEOUT_EN.

Behaviour:
- Reset: sync flops, edge-history, pending, pend_o, pend_valid_o, busy_o, err_o and timeout_o are all 0; FSM goes to IDLE. Reset mid-operation discards all pending and in-flight state.
- Capture, edge bit: pending[i] is set when sync[i] is 1 and the previous sync[i] was 0.
- Capture, level bit: pending[i] is set every cycle sync[i] is 1.
- Capture latency (SYNC_STAGES=2): req_i first sampled high at edge t -> pending set at edge t+2 -> pend_valid_o high after edge t+3.
- Clear: done_i clears pending[done_idx_i].
  - If a set and the clear hit the same bit in the same cycle, set wins; no request is lost.
  - A level bit that is still high re-sets on the next cycle.
- FSM IDLE:
  - If (pending & ~mask_i) != 0, register pend_o = pending & ~mask_i, set pend_valid_o = 1, go to PRESENT.
  - Otherwise pend_o = 0.
- FSM PRESENT:
  - pend_o and pend_valid_o are held stable; new requests and mask changes do not alter pend_o.
  - When pend_ready_i = 1: pend_valid_o = 0 next cycle, go to SERVICE.
  - ready may be held high permanently; the transfer then takes exactly 1 cycle.
- FSM SERVICE:
  - pend_o stays held.
  - If done_i = 1 and pend_o[done_idx_i] = 1: clear the bit, go to IDLE.
  - If done_i = 1 and pend_o[done_idx_i] = 0: err_o pulses, no clear, stay in SERVICE.
  - done_i outside SERVICE is ignored and raises no error.
- Re-presentation: earliest new pend_valid_o is 1 cycle after the IDLE return, so back-to-back snapshots are separated by at least 1 idle cycle.
- Masked bits stay pending and are presented once unmasked.
- busy_o = (state != IDLE), registered.

Optional Feature:
- Macro IRQ_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to SERVICE and increments each cycle in SERVICE.
  - When the count reaches TIMEOUT_CYCLES without a valid done: timeout_o pulses for 1 cycle, the FSM returns to IDLE, and pending is left untouched, so the request is re-presented.
  - A valid done in the same cycle as the timeout wins: normal clear, no pulse.
- Undefined: no counter; the timeout_o port is absent; SERVICE waits indefinitely.

Decomposition:
- Package irq_pkg:
  - NUM_REQ = 8 and IDX_W = 3.
  - typedef req_vec_t as logic [7:0].
  - typedef enum state_t {IDLE, PRESENT, SERVICE}.
- One sub-module, irq_sync_edge: per-bit synchroniser chain plus edge/level qualifier, parameterised by SYNC_STAGES and edge select, instantiated 8 times.
- The pending register, FSM and timeout counter live in the top module.

Test Plan:
- Reset then idle: req_i=0 for 20 cycles -> pend_valid_o=0, pend_o=8'h00, busy_o=0.
- Single edge: pulse req_i[5] for 1 cycle, ready=1 -> pend_valid_o high after edge t+3 with pend_o=8'h20; done_idx=5 -> pending clears; no re-presentation.
- Stable snapshot: req_i[2] then req_i[7] 1 cycle later, ready held 0 -> pend_o=8'h04 held until ready; done_idx=2 -> next snapshot pend_o=8'h80.
- Mask: mask_i=8'h08, pulse req_i[3] -> no pend_valid_o; clear the mask -> pend_o=8'h08 presented.
- Error/collision: in SERVICE with pend_o=8'h10, done_idx=1 -> err_o pulses and state stays SERVICE; an edge on bit 4 in the same cycle as done_idx=4 -> bit 4 is re-presented.
- With IRQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: accept, then withhold done -> timeout_o pulses at cycle 16 of SERVICE and the same pend_o is re-presented.

Source files
------------

// File: rtl/irq_pending_collector_pkg.sv
// Shared types for the interrupt pending collector that feeds the 8-to-3 priority encoder.
package irq_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
endpackage

// File: rtl/irq_pending_collector_if.sv
// Collector <-> encoder/consumer bundle; master = collector, slave = consumer side.
interface irq_pending_collector_if;
  import irq_pkg::*;

  req_vec_t           req_i;
  req_vec_t           mask_i;
  req_vec_t           pend_o;
  logic               pend_valid_o;
  logic               pend_ready_i;
  logic               done_i;
  logic [IDX_W-1:0]   done_idx_i;
  logic               busy_o;
  logic               err_o;
`ifdef IRQ_TIMEOUT_EN
  logic               timeout_o;
`endif

  modport master (
    input  req_i, mask_i, pend_ready_i, done_i, done_idx_i,
    output pend_o, pend_valid_o, busy_o, err_o
`ifdef IRQ_TIMEOUT_EN
    , output timeout_o
`endif
  );

  modport slave (
    output req_i, mask_i, pend_ready_i, done_i, done_idx_i,
    input  pend_o, pend_valid_o, busy_o, err_o
`ifdef IRQ_TIMEOUT_EN
    , input timeout_o
`endif
  );
endinterface

// File: rtl/irq_pending_collector_sync_edge.sv
// One request line: metastability synchroniser followed by a rising-edge or level qualifier.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic set
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign set = EDGE ? (sync_q[SYNC_STAGES-1] & ~hist_q) : sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/irq_pending_collector.sv
// Pending accumulator + snapshot FSM in front of the priority encoder.
// Optional SERVICE watchdog enabled by defining IRQ_TIMEOUT_EN.
module irq_pending_collector
  import irq_pkg::*;
#(
  parameter int       SYNC_STAGES = 2,
  parameter logic [NUM_REQ-1:0] EDGE_MASK = 8'hFF
`ifdef IRQ_TIMEOUT_EN
  , parameter int     TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  irq_pending_collector_if.master bus
);
  req_vec_t set, pending_q, pending_d, clr, vis;
  req_vec_t pend_q, pend_d;
  state_t   state_q, state_d;
  logic     valid_q, valid_d, busy_q, err_q, err_d, done_ok;
`ifdef IRQ_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       to_q, to_d;
  assign cnt_inc = cnt_q + 8'd1;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(EDGE_MASK[gi])) u_sync (
      .clk (clk),
      .rst (rst),
      .req (bus.req_i[gi]),
      .set (set[gi])
    );
  end

  // Only a done that names a bit of the held snapshot counts as service.
  assign done_ok   = (state_q == SERVICE) && bus.done_i && pend_q[bus.done_idx_i];
  // Set is OR-ed in after the clear so a simultaneous new request survives.
  assign pending_d = (pending_q & ~clr) | set;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    clr     = '0;
    vis     = pending_q & ~bus.mask_i;
`ifdef IRQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|vis) begin
          pend_d  = vis;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          pend_d  = '0;
        end
      end
      PRESENT: begin
        if (bus.pend_ready_i) begin
          valid_d = 1'b0;
          state_d = SERVICE;
`ifdef IRQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      SERVICE: begin
        if (done_ok) begin
          clr[bus.done_idx_i] = 1'b1;
          state_d = IDLE;
        end else begin
          if (bus.done_i) err_d = 1'b1;
`ifdef IRQ_TIMEOUT_EN
          if (cnt_inc == TO_LIM) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_inc;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign bus.pend_o       = pend_q;
  assign bus.pend_valid_o = valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.err_o        = err_q;
`ifdef IRQ_TIMEOUT_EN
  assign bus.timeout_o    = to_q;
`endif
endmodule

// File: tb/tb_irq_pending_collector.sv
// Directed + random bench for irq_pending_collector against a behavioural model.
module tb_irq_pending_collector;
  import irq_pkg::*;

`ifdef IRQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_pending_collector_if bus();

`ifdef IRQ_TIMEOUT_EN
  irq_pending_collector #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  irq_pending_collector dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // Model: req history (sampled at each edge), pending set, and the consumer's view.
  // phase 0 = nothing offered, 1 = snapshot offered, 2 = consumer owns snapshot.
  typedef struct {
    logic [7:0] h0, h1, h2;
    logic [7:0] pend, snap;
    logic       valid, busy, err, to;
    int         phase, held;
  } mdl_t;

  mdl_t m;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic mdl_t mdl_next(mdl_t c, logic [7:0] req, logic [7:0] mask,
                                     logic ready, logic done, logic [2:0] idx);
    mdl_t n = c;
    // A request becomes visible two edges after sampling; it counts once per 0->1.
    logic [7:0] rise = c.h1 & ~c.h2;
    bit good = (c.phase == 2) && done && c.snap[idx];
    n.h2 = c.h1; n.h1 = c.h0; n.h0 = req;
    if (good) n.pend[idx] = 1'b0;
    n.pend = n.pend | rise;
    n.err = 1'b0;
    n.to  = 1'b0;
    case (c.phase)
      0: if ((c.pend & ~mask) != 8'h00) begin
           n.snap = c.pend & ~mask; n.valid = 1'b1; n.phase = 1;
         end else n.snap = 8'h00;
      1: if (ready) begin n.valid = 1'b0; n.phase = 2; n.held = 0; end
      default: if (good) n.phase = 0;
               else begin
                 if (done) n.err = 1'b1;
                 n.held = c.held + 1;
                 if (TMO_EN && n.held == TMO) begin n.to = 1'b1; n.phase = 0; end
               end
    endcase
    n.busy = (n.phase != 0);
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= '{default: 0};
    else     m <= mdl_next(m, bus.req_i, bus.mask_i, bus.pend_ready_i, bus.done_i, bus.done_idx_i);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("pend_o",  bus.pend_o,       m.snap);
    chk("valid",   bus.pend_valid_o, m.valid);
    chk("busy",    bus.busy_o,       m.busy);
    chk("err",     bus.err_o,        m.err);
`ifdef IRQ_TIMEOUT_EN
    chk("timeout", bus.timeout_o,    m.to);
`endif
  endtask

  task automatic pulse(int b);
    bus.req_i[b] = 1'b1;
    step();
    bus.req_i[b] = 1'b0;
  endtask

  task automatic wait_valid(string tag);
    int k = 0;
    while (!bus.pend_valid_o && k < 40) begin step(); k++; end
    chk(tag, bus.pend_valid_o, 1'b1);
  endtask

  task automatic accept();
    bus.pend_ready_i = 1'b1;
    step();
    bus.pend_ready_i = 1'b0;
  endtask

  task automatic done_pulse(logic [2:0] idx);
    bus.done_i = 1'b1; bus.done_idx_i = idx;
    step();
    bus.done_i = 1'b0;
  endtask

  initial begin
    bus.req_i = '0; bus.mask_i = '0; bus.pend_ready_i = 1'b0;
    bus.done_i = 1'b0; bus.done_idx_i = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    chk("idle_valid", bus.pend_valid_o, 1'b0);
    chk("idle_pend",  bus.pend_o, 8'h00);
    chk("idle_busy",  bus.busy_o, 1'b0);

    // Single edge, ready held high: valid appears after the 4th edge.
    bus.pend_ready_i = 1'b1;
    pulse(5);
    step(); step();
    chk("lat_early", bus.pend_valid_o, 1'b0);
    step();
    chk("lat_valid", bus.pend_valid_o, 1'b1);
    chk("lat_pend",  bus.pend_o, 8'h20);
    step();
    chk("xfer_valid", bus.pend_valid_o, 1'b0);
    chk("xfer_busy",  bus.busy_o, 1'b1);
    bus.pend_ready_i = 1'b0;
    done_pulse(3'd5);
    chk("clr_busy", bus.busy_o, 1'b0);
    repeat (6) step();
    chk("no_repres", bus.pend_valid_o, 1'b0);

    // Stable snapshot while ready is low.
    pulse(2);
    pulse(7);
    wait_valid("stable_vld");
    chk("stable_first", bus.pend_o, 8'h04);
    repeat (5) step();
    chk("stable_hold", bus.pend_o, 8'h04);
    accept();
    done_pulse(3'd2);
    wait_valid("second_vld");
    chk("second_pend", bus.pend_o, 8'h80);
    accept();
    done_pulse(3'd7);

    // Masked request stays pending until unmasked.
    bus.mask_i = 8'h08;
    pulse(3);
    repeat (8) step();
    chk("mask_hidden", bus.pend_valid_o, 1'b0);
    bus.mask_i = 8'h00;
    wait_valid("unmask_vld");
    chk("unmask_pend", bus.pend_o, 8'h08);
    accept();
    done_pulse(3'd3);

    // Wrong index -> err, then a new edge on bit 4 colliding with its clear.
    pulse(4);
    wait_valid("err_vld");
    chk("err_snap", bus.pend_o, 8'h10);
    accept();
    bus.done_i = 1'b1; bus.done_idx_i = 3'd1;
    step();
    bus.done_i = 1'b0;
    chk("err_pulse", bus.err_o, 1'b1);
    chk("err_stay",  bus.busy_o, 1'b1);
    step();
    chk("err_once",  bus.err_o, 1'b0);
    bus.req_i[4] = 1'b1;
    step();
    bus.req_i[4] = 1'b0;
    step();
    done_pulse(3'd4);
    chk("coll_idle", bus.busy_o, 1'b0);
    wait_valid("coll_vld");
    chk("coll_pend", bus.pend_o, 8'h10);
    accept();
    done_pulse(3'd4);
    repeat (4) step();

`ifdef IRQ_TIMEOUT_EN
    begin
      int k = 0;
      pulse(1);
      wait_valid("tmo_vld");
      accept();
      while (!bus.timeout_o && k < 30) begin step(); k++; end
      chk("tmo_pulse", bus.timeout_o, 1'b1);
      chk("tmo_cycle", k, TMO);
      wait_valid("tmo_repres");
      chk("tmo_pend", bus.pend_o, 8'h02);
      accept();
      done_pulse(3'd1);
    end
`endif

    // Reset mid-operation discards captured requests.
    bus.req_i = 8'h41;
    step();
    bus.req_i = 8'h00;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("rst_valid", bus.pend_valid_o, 1'b0);
    chk("rst_busy",  bus.busy_o, 1'b0);
    rst = 1'b0;
    repeat (10) step();
    chk("rst_discard", bus.pend_valid_o, 1'b0);

    // Random traffic: sparse requests, occasional masks, random ready/done.
    for (int i = 0; i < 400; i++) begin
      bus.req_i        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.mask_i       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      bus.pend_ready_i = 1'($urandom);
      bus.done_i       = ($urandom_range(0, 3) == 0);
      bus.done_idx_i   = 3'($urandom);
      if (m.phase == 2 && $urandom_range(0, 1) == 1) begin
        for (int b = 7; b >= 0; b--) if (m.snap[b]) bus.done_idx_i = 3'(b);
      end
      step();
    end
    bus.req_i = '0; bus.mask_i = '0; bus.done_i = 1'b0; bus.pend_ready_i = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
